gpu_launch_ctrl: RTL
====================

# gpu_launch_ctrl

Parametrised kernel-launch controller for the thread datapath. On a start pulse it resets the thread array for a configurable number of cycles, enables a masked subset of up to NUM_THREADS threads, tracks per-thread completion, and finishes on all-done or on a programmable timeout. It sits between the host/test driver and `top`, replacing fixed-length reset-and-run sequencing with a synthesizable, measurable launch.

## Interface
- NUM_THREADS, 4: thread lanes controlled (1..32)
- RESET_CYCLES, 2: cycles thread_reset is held per launch (>=1)
- TIMEOUT_W, 16: width of timeout_limit
- CYCLE_W, 32: width of cycle counters
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; low = all state to reset values
- start  in  1  launch pulse; honoured only in IDLE or DONE
- thread_mask  in  NUM_THREADS  threads to run; latched on accepted start
- timeout_limit  in  TIMEOUT_W  max RUN cycles; 0 = no timeout; latched on start
- thread_done  in  NUM_THREADS  per-thread completion (level or pulse)
- thread_reset  out  1  synchronous active-high reset to datapath
- thread_enable  out  NUM_THREADS  per-thread run enable
- busy  out  1  high in RESET and RUN
- done  out  1  high in DONE
- timed_out  out  1  high in DONE when ended by timeout
- cycle_count  out  CYCLE_W  RUN cycles elapsed in current/last launch
- thread_cycles  out  NUM_THREADS*CYCLE_W  per-thread completion cycle (see Configuration)

## Operation
- States: IDLE, RESET, RUN, DONE. All outputs registered.
- Reset values: state IDLE; thread_reset 0; thread_enable 0; busy, done, timed_out 0; cycle_count 0; thread_cycles 0; latched mask/limit 0.
- IDLE/DONE + start: latch thread_mask and timeout_limit; clear sticky done bits, cycle_count, thread_cycles, done, timed_out; go RESET.
- RESET: thread_reset=1, reset-cycle counter runs; after RESET_CYCLES cycles go RUN.
- RUN: thread_enable[i] = mask[i] & ~sticky[i]; each edge sticky[i] |= thread_done[i] & mask[i]; cycle_count += 1 (saturates at all-ones).
- RUN exit, evaluated each edge using updated sticky: all masked threads done -> DONE, timed_out=0; else if limit!=0 and cycle_count+1 == limit -> DONE, timed_out=1. All-done wins on same edge.
- DONE: enables 0, done held until next accepted start; cycle_count and thread_cycles hold.
- start in RESET/RUN ignored. thread_done on unmasked lanes ignored.
- Zero mask: first RUN edge finds all-done; DONE with cycle_count=1.
- reset asserted mid-launch: immediate return to reset values, no completion reported.

## Timing
- start sampled at edge k in IDLE: thread_reset high cycles k+1..k+RESET_CYCLES; RUN from k+RESET_CYCLES+1, thread_enable=mask that cycle.
- thread_done[i] seen at edge e: thread_enable[i] low from e+1.
- Final completion at RUN edge n (n-th RUN edge, 1-based): DONE from next cycle, done=1, cycle_count=n.
- Timeout limit L: DONE after exactly L RUN cycles, cycle_count=L.
- Back-to-back: start in DONE accepted same as IDLE; done drops the next cycle.

## Configuration
- GPU_LAUNCH_PERF_EN defined: per-thread register thread_cycles[i] captures cycle_count+1 on the edge sticky[i] first sets; unmasked or never-done lanes read 0.
- Not defined: no per-thread registers; thread_cycles tied to 0; all other behaviour identical.

## Structure
- Package gpu_launch_pkg: state enum (IDLE, RESET, RUN, DONE), state width constant, default parameter constants.
- One sub-module: gpu_done_tracker (sticky bits, mask, all-done reduction, optional per-thread cycle capture).
- Controller FSM, reset-cycle counter, run counter in gpu_launch_ctrl.

## Test plan
- Reset low mid-RUN with mask 4'b1111 -> all outputs 0, state IDLE next edge; later start works normally.
- NUM_THREADS=4, RESET_CYCLES=2, mask 4'b1011, done lanes 0,1,3 at RUN cycles 3,5,7 -> thread_reset 2 cycles, enables drop per lane, done=1, timed_out=0, cycle_count=7; with GPU_LAUNCH_PERF_EN thread_cycles = {7,0,5,3}.
- mask 4'b0001, limit 10, thread 0 never done -> DONE after 10 RUN cycles, timed_out=1, cycle_count=10.
- Limit 6, last thread done on 6th RUN edge -> timed_out=0, cycle_count=6 (all-done priority).
- mask 0 -> done after 1 RUN cycle, cycle_count=1; start pulses during RESET/RUN of a long launch ignored.
- Start asserted in DONE -> new launch, done low next cycle, counters cleared, second result independent of first.

Source files
------------

// File: rtl/gpu_launch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpu_launch_pkg
// Purpose  : Shared types and default parameters for the kernel-launch
//            controller (state encoding, state width, default sizes).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package gpu_launch_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } launch_state_t;

    localparam int DEF_NUM_THREADS  = 4;
    localparam int DEF_RESET_CYCLES = 2;
    localparam int DEF_TIMEOUT_W    = 16;
    localparam int DEF_CYCLE_W      = 32;

endpackage
`default_nettype wire

// File: rtl/gpu_launch_if.sv
`default_nettype none
// ============================================================================
// Module   : gpu_launch_if
// Purpose  : Launch-control bundle between host/datapath (master) and the
//            launch controller (slave).
// Signals  : start, thread_mask, timeout_limit, thread_done   (master -> slave)
//            thread_reset, thread_enable, busy, done, timed_out,
//            cycle_count, thread_cycles                       (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface gpu_launch_if
    import gpu_launch_pkg::*;
#(
    parameter int NUM_THREADS = DEF_NUM_THREADS,
    parameter int TIMEOUT_W   = DEF_TIMEOUT_W,
    parameter int CYCLE_W     = DEF_CYCLE_W
) ();

    logic                           start;
    logic [NUM_THREADS-1:0]         thread_mask;
    logic [TIMEOUT_W-1:0]           timeout_limit;
    logic [NUM_THREADS-1:0]         thread_done;

    logic                           thread_reset;
    logic [NUM_THREADS-1:0]         thread_enable;
    logic                           busy;
    logic                           done;
    logic                           timed_out;
    logic [CYCLE_W-1:0]             cycle_count;
    logic [NUM_THREADS*CYCLE_W-1:0] thread_cycles;

    modport master (
        output start, thread_mask, timeout_limit, thread_done,
        input  thread_reset, thread_enable, busy, done, timed_out,
               cycle_count, thread_cycles
    );

    modport slave (
        input  start, thread_mask, timeout_limit, thread_done,
        output thread_reset, thread_enable, busy, done, timed_out,
               cycle_count, thread_cycles
    );

endinterface
`default_nettype wire

// File: rtl/gpu_done_tracker.sv
`default_nettype none
// ============================================================================
// Module   : gpu_done_tracker
// Purpose  : Holds the latched thread mask and per-lane sticky completion
//            bits, produces the all-done reduction on the updated sticky
//            state, and (with GPU_LAUNCH_PERF_EN defined) records the run
//            cycle at which each lane first completed.
// Ports    : clk, rst_n        clock / async active-low reset
//            launch            accepted start: latch mask, clear history
//            run               controller is in RUN this cycle
//            mask_in           thread mask to latch on launch
//            thread_done       per-lane completion from the datapath
//            cycle_next        run-cycle value being written this edge
//            mask              latched mask
//            sticky_next       sticky bits as they will be after this edge
//            all_done_next     every masked lane done after this edge
//            thread_cycles     per-lane completion cycle (0 when disabled)
// Config   : GPU_LAUNCH_PERF_EN enables the per-lane cycle registers.
// Revision : 1.0 - initial release
// ============================================================================
module gpu_done_tracker
    import gpu_launch_pkg::*;
#(
    parameter int NUM_THREADS = DEF_NUM_THREADS,
    parameter int CYCLE_W     = DEF_CYCLE_W
) (
    input  wire logic                           clk,
    input  wire logic                           rst_n,
    input  wire logic                           launch,
    input  wire logic                           run,
    input  wire logic [NUM_THREADS-1:0]         mask_in,
    input  wire logic [NUM_THREADS-1:0]         thread_done,
    input  wire logic [CYCLE_W-1:0]             cycle_next,
    output logic      [NUM_THREADS-1:0]         mask,
    output logic      [NUM_THREADS-1:0]         sticky_next,
    output logic                                all_done_next,
    output logic      [NUM_THREADS*CYCLE_W-1:0] thread_cycles
);

    logic [NUM_THREADS-1:0] r_mask;
    logic [NUM_THREADS-1:0] r_sticky;
    logic [NUM_THREADS-1:0] w_new_done;

    // Lanes completing for the first time on this edge; unmasked lanes
    // can never contribute.
    assign w_new_done = thread_done & r_mask & ~r_sticky;

    always_comb begin
        sticky_next = r_sticky;
        if (launch) begin
            sticky_next = '0;
        end else if (run) begin
            sticky_next = r_sticky | w_new_done;
        end
    end

    // Unmasked lanes count as done, so an empty mask completes at once.
    assign all_done_next = &(sticky_next | ~r_mask);
    assign mask          = r_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask   <= '0;
            r_sticky <= '0;
        end else begin
            if (launch) begin
                r_mask <= mask_in;
            end
            r_sticky <= sticky_next;
        end
    end

`ifdef GPU_LAUNCH_PERF_EN
    for (genvar i = 0; i < NUM_THREADS; i++) begin : g_perf_lane
        logic [CYCLE_W-1:0] r_cycles;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cycles <= '0;
            end else if (launch) begin
                r_cycles <= '0;
            end else if (run && w_new_done[i]) begin
                r_cycles <= cycle_next;
            end
        end

        assign thread_cycles[i*CYCLE_W +: CYCLE_W] = r_cycles;
    end : g_perf_lane
`else
    logic unused_cycle_next;
    assign unused_cycle_next = ^cycle_next;
    assign thread_cycles     = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/gpu_launch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gpu_launch_ctrl
// Purpose  : Kernel-launch controller. A start pulse holds the thread array
//            in reset for RESET_CYCLES, runs the masked threads, and finishes
//            when every masked thread is done or the run-cycle limit expires.
// Ports    : clk     clock, rising edge
//            rst_n   asynchronous active-low reset
//            bus     gpu_launch_if.slave: start/thread_mask/timeout_limit/
//                    thread_done in; thread_reset/thread_enable/busy/done/
//                    timed_out/cycle_count/thread_cycles out (all registered)
// Config   : GPU_LAUNCH_PERF_EN enables per-thread completion-cycle capture.
// Revision : 1.0 - initial release
// ============================================================================
module gpu_launch_ctrl
    import gpu_launch_pkg::*;
#(
    parameter int NUM_THREADS  = DEF_NUM_THREADS,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int TIMEOUT_W    = DEF_TIMEOUT_W,
    parameter int CYCLE_W      = DEF_CYCLE_W
) (
    input wire logic  clk,
    input wire logic  rst_n,
    gpu_launch_if.slave bus
);

    localparam int RST_CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    // One bit wider than either operand so cycle_count+1 never wraps in
    // the timeout comparison.
    localparam int CMP_W = ((CYCLE_W > TIMEOUT_W) ? CYCLE_W : TIMEOUT_W) + 1;
    localparam logic [RST_CNT_W-1:0] c_rst_last = RST_CNT_W'(RESET_CYCLES - 1);

    launch_state_t          r_state, w_state_next;
    logic [RST_CNT_W-1:0]   r_rst_cnt, w_rst_cnt_next;
    logic [TIMEOUT_W-1:0]   r_limit, w_limit_next;
    logic [CYCLE_W-1:0]     r_cycle_count, w_cycle_count_next;
    logic                   r_thread_reset, w_thread_reset_next;
    logic [NUM_THREADS-1:0] r_thread_enable, w_thread_enable_next;
    logic                   r_busy, w_busy_next;
    logic                   r_done, w_done_next;
    logic                   r_timed_out, w_timed_out_next;

    logic                   w_accept;
    logic                   w_run;
    logic [CYCLE_W-1:0]     w_cycle_inc;
    logic                   w_timeout_hit;
    logic [NUM_THREADS-1:0] w_mask;
    logic [NUM_THREADS-1:0] w_sticky_next;
    logic                   w_all_done_next;

    assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_run    = (r_state == RUN);

    assign w_cycle_inc = (&r_cycle_count) ? r_cycle_count
                                          : r_cycle_count + CYCLE_W'(1);

    assign w_timeout_hit = (r_limit != '0) &&
                           ((CMP_W'(r_cycle_count) + CMP_W'(1)) == CMP_W'(r_limit));

    gpu_done_tracker #(
        .NUM_THREADS (NUM_THREADS),
        .CYCLE_W     (CYCLE_W)
    ) u_tracker (
        .clk           (clk),
        .rst_n         (rst_n),
        .launch        (w_accept),
        .run           (w_run),
        .mask_in       (bus.thread_mask),
        .thread_done   (bus.thread_done),
        .cycle_next    (w_cycle_inc),
        .mask          (w_mask),
        .sticky_next   (w_sticky_next),
        .all_done_next (w_all_done_next),
        .thread_cycles (bus.thread_cycles)
    );

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        w_state_next         = r_state;
        w_rst_cnt_next       = r_rst_cnt;
        w_limit_next         = r_limit;
        w_cycle_count_next   = r_cycle_count;
        w_thread_reset_next  = r_thread_reset;
        w_thread_enable_next = r_thread_enable;
        w_busy_next          = r_busy;
        w_done_next          = r_done;
        w_timed_out_next     = r_timed_out;

        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_state_next         = RESET;
                    w_rst_cnt_next       = '0;
                    w_limit_next         = bus.timeout_limit;
                    w_cycle_count_next   = '0;
                    w_thread_reset_next  = 1'b1;
                    w_thread_enable_next = '0;
                    w_busy_next          = 1'b1;
                    w_done_next          = 1'b0;
                    w_timed_out_next     = 1'b0;
                end
            end

            RESET: begin
                if (r_rst_cnt == c_rst_last) begin
                    w_state_next         = RUN;
                    w_thread_reset_next  = 1'b0;
                    w_thread_enable_next = w_mask;
                end else begin
                    w_rst_cnt_next = r_rst_cnt + RST_CNT_W'(1);
                end
            end

            RUN: begin
                w_cycle_count_next = w_cycle_inc;
                // All-done is tested first so it wins over a same-edge timeout.
                if (w_all_done_next) begin
                    w_state_next         = DONE;
                    w_thread_enable_next = '0;
                    w_busy_next          = 1'b0;
                    w_done_next          = 1'b1;
                    w_timed_out_next     = 1'b0;
                end else if (w_timeout_hit) begin
                    w_state_next         = DONE;
                    w_thread_enable_next = '0;
                    w_busy_next          = 1'b0;
                    w_done_next          = 1'b1;
                    w_timed_out_next     = 1'b1;
                end else begin
                    w_thread_enable_next = w_mask & ~w_sticky_next;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_rst_cnt       <= '0;
            r_limit         <= '0;
            r_cycle_count   <= '0;
            r_thread_reset  <= 1'b0;
            r_thread_enable <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_timed_out     <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_rst_cnt       <= w_rst_cnt_next;
            r_limit         <= w_limit_next;
            r_cycle_count   <= w_cycle_count_next;
            r_thread_reset  <= w_thread_reset_next;
            r_thread_enable <= w_thread_enable_next;
            r_busy          <= w_busy_next;
            r_done          <= w_done_next;
            r_timed_out     <= w_timed_out_next;
        end
    end

    assign bus.thread_reset  = r_thread_reset;
    assign bus.thread_enable = r_thread_enable;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.timed_out     = r_timed_out;
    assign bus.cycle_count   = r_cycle_count;

endmodule
`default_nettype wire
